// File: rtl/led_seg_out_pkg.sv
// Shared constants for the LED / 7-segment output peripheral: register
// addresses, the hex-to-segment table and the digit-enable mask.
package led_seg_out_pkg;

   localparam logic [1:0] LED_ADDR_LO   = 2'b00;
   localparam logic [1:0] LED_ADDR_FULL = 2'b01;
   localparam logic [1:0] LED_ADDR_HI   = 2'b10;
   localparam logic [1:0] SEG_ADDR_DISP = 2'b11;

   // Only the low four enables have digits behind them.
   localparam logic [7:0] SEG_EN_MASK = 8'h0F;

   // Segment codes {a,b,c,d,e,f,g,dp}, indexed by nibble value; dp is always 0.
   localparam logic [0:15][7:0] HEX_SEG = {
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
   };

   typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/led_seg_out_seg_hex_decode.sv
// Combinational nibble to 7-segment code decoder, shared by display blocks.
module seg_hex_decode
   import led_seg_out_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [7:0] seg_o
);

   assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/led_seg_out.sv
// Memory-mapped LED and 4-digit 7-segment output block, clocked on the falling
// edge of ledclk. Optional build macro: SEG_LEADING_ZERO_BLANK_EN.
module led_seg_out
   import led_seg_out_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 100000,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic        ledclk,
   input  logic        ledrst,
   input  logic        ledcs,
   input  logic        ledwrite,
   input  logic [1:0]  ledaddr,
   input  logic [15:0] ledwdata,
   output logic [15:0] led_out,
   output logic [7:0]  seg_en,
   output logic [7:0]  seg_out
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);

   logic [15:0]      led_q,     led_d;
   logic [15:0]      disp_q,    disp_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   digit_idx_t       digit_q,   digit_d;
   logic [7:0]       seg_en_q,  seg_en_d;
   logic [7:0]       seg_out_q, seg_out_d;

   logic [3:0]       nibble;
   logic [7:0]       dec_seg;
   logic             blank;

   seg_hex_decode u_hex_decode (
      .nib_i (nibble),
      .seg_o (dec_seg)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      led_d  = led_q;
      disp_d = disp_q;
      if (ledcs && ledwrite) begin
         case (ledaddr)
            LED_ADDR_LO:   led_d[7:0]  = ledwdata[7:0];
            LED_ADDR_HI:   led_d[15:8] = ledwdata[7:0];
            LED_ADDR_FULL: led_d       = ledwdata;
            SEG_ADDR_DISP: disp_d      = ledwdata;
            default:       led_d       = led_q;
         endcase
      end
   end

   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      digit_d = digit_q;
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         cnt_d   = '0;
         digit_d = (digit_q == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : digit_q + 2'd1;
      end
   end

   // Segments follow the digit being entered and the disp value before any write.
   always_comb begin
      nibble = 4'(disp_q >> {digit_d, 2'b00});
`ifdef SEG_LEADING_ZERO_BLANK_EN
      blank  = (digit_d != '0) && ((disp_q >> {digit_d, 2'b00}) == 16'h0000);
`else
      blank  = 1'b0;
`endif
      seg_out_d = blank ? 8'h00 : dec_seg;
      seg_en_d  = (8'h01 << digit_d) & SEG_EN_MASK;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(negedge ledclk or posedge ledrst) begin
      if (ledrst) begin
         led_q     <= '0;
         disp_q    <= '0;
         cnt_q     <= '0;
         digit_q   <= '0;
         seg_en_q  <= 8'h01;
         seg_out_q <= HEX_SEG[0];
      end else begin
         led_q     <= led_d;
         disp_q    <= disp_d;
         cnt_q     <= cnt_d;
         digit_q   <= digit_d;
         seg_en_q  <= seg_en_d;
         seg_out_q <= seg_out_d;
      end
   end

   assign led_out = led_q;
   assign seg_en  = seg_en_q;
   assign seg_out = seg_out_q;

endmodule

// File: tb/tb_led_seg_out.sv
// Scoreboard bench for led_seg_out with SCAN_DIV=4: stimulus pushes expected
// outputs after each falling edge, a monitor compares them on the rising edge.
module tb_led_seg_out;

   logic        ledclk = 1'b1;
   logic        ledrst = 1'b1;
   logic        ledcs = 1'b0;
   logic        ledwrite = 1'b0;
   logic [1:0]  ledaddr = 2'b00;
   logic [15:0] ledwdata = 16'h0000;
   logic [15:0] led_out;
   logic [7:0]  seg_en;
   logic [7:0]  seg_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      bit          chk_led;
      logic [15:0] led;
      bit          chk_seg;
      logic [7:0]  en;
      logic [7:0]  seg;
   } exp_t;

   exp_t sb[$];

   localparam logic [7:0] ZERO_DIG =
`ifdef SEG_LEADING_ZERO_BLANK_EN
      8'h00;
`else
      8'hFC;
`endif

   // Expected enables/segments after edges 1..16 once disp=1234 is written on edge 1.
   logic [7:0] scan_en [16] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04,
                                8'h04, 8'h04, 8'h04, 8'h08, 8'h08, 8'h08, 8'h08, 8'h01};
   logic [7:0] scan_sg [16] = '{8'hFC, 8'h66, 8'h66, 8'hF2, 8'hF2, 8'hF2, 8'hF2, 8'hDA,
                                8'hDA, 8'hDA, 8'hDA, 8'h60, 8'h60, 8'h60, 8'h60, 8'h66};

   led_seg_out #(.SCAN_DIV(4), .NUM_DIGITS(4)) dut (
      .ledclk   (ledclk),
      .ledrst   (ledrst),
      .ledcs    (ledcs),
      .ledwrite (ledwrite),
      .ledaddr  (ledaddr),
      .ledwdata (ledwdata),
      .led_out  (led_out),
      .seg_en   (seg_en),
      .seg_out  (seg_out)
   );

   always #5 ledclk = ~ledclk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_led(input string name, input logic [15:0] led);
      sb.push_back('{name, 1'b1, led, 1'b0, 8'h00, 8'h00});
   endtask

   task automatic push_seg(input string name, input logic [7:0] en, input logic [7:0] seg);
      sb.push_back('{name, 1'b0, 16'h0000, 1'b1, en, seg});
   endtask

   task automatic push_all(input string name, input logic [15:0] led,
                           input logic [7:0] en, input logic [7:0] seg);
      sb.push_back('{name, 1'b1, led, 1'b1, en, seg});
   endtask

   // Present one bus cycle, let a falling edge take it, then return the bus to idle.
   task automatic tick(input logic cs, input logic we, input logic [1:0] addr,
                       input logic [15:0] data);
      ledcs    = cs;
      ledwrite = we;
      ledaddr  = addr;
      ledwdata = data;
      @(negedge ledclk);
      #1;
      ledcs    = 1'b0;
      ledwrite = 1'b0;
      ledaddr  = 2'b00;
      ledwdata = 16'h0000;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'b00, 16'h0000);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge ledclk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_led) check({e.name, ".led_out"}, led_out, e.led);
            if (e.chk_seg) begin
               check({e.name, ".seg_en"}, {8'h00, seg_en}, {8'h00, e.en});
               check({e.name, ".seg_out"}, {8'h00, seg_out}, {8'h00, e.seg});
            end
         end
      end
   end

   initial begin : stimulus
      repeat (2) @(negedge ledclk);
      #1;
      push_all("reset_hold", 16'h0000, 8'h01, 8'hFC);
      @(posedge ledclk);
      #1;
      ledrst = 1'b0;

      // Scan with disp=1234 written on the first edge after release.
      tick(1'b1, 1'b1, 2'b11, 16'h1234);
      push_seg("scan_e1", scan_en[0], scan_sg[0]);
      for (int e = 1; e < 16; e++) begin
         idle(1);
         push_seg($sformatf("scan_e%0d", e + 1), scan_en[e], scan_sg[e]);
      end

      // LED writes during digit 0 (edges 17..19), full write on wrap edge 20.
      tick(1'b1, 1'b1, 2'b00, 16'h00A5);
      push_all("byte_lo", 16'h00A5, 8'h01, 8'h66);
      tick(1'b1, 1'b1, 2'b10, 16'h003C);
      push_all("byte_hi", 16'h3CA5, 8'h01, 8'h66);
      tick(1'b0, 1'b1, 2'b01, 16'hFFFF);
      push_all("no_cs", 16'h3CA5, 8'h01, 8'h66);
      tick(1'b1, 1'b1, 2'b01, 16'h1234);
      push_all("full_write", 16'h1234, 8'h02, 8'hF2);

      // Write disp=ABCD on edge 36, the wrap into digit 1.
      idle(15);
      tick(1'b1, 1'b1, 2'b11, 16'hABCD);
      push_seg("wrap_write_e36", 8'h02, 8'hF2);
      for (int e = 37; e <= 39; e++) begin
         idle(1);
         push_seg($sformatf("wrap_hold_e%0d", e), 8'h02, 8'h9C);
      end
      idle(1);
      push_seg("wrap_next_e40", 8'h04, 8'h3E);
      idle(2);
      push_all("digit2_e42", 16'h1234, 8'h04, 8'h3E);

      // Asynchronous reset in the middle of digit 2.
      @(posedge ledclk);
      #1;
      ledrst = 1'b1;
      #1;
      push_all("reset_async", 16'h0000, 8'h01, 8'hFC);
      @(negedge ledclk);
      @(posedge ledclk);
      #1;
      ledrst = 1'b0;

      // Leading-digit behaviour with disp=0007.
      tick(1'b1, 1'b1, 2'b11, 16'h0007);
      push_all("z_e1", 16'h0000, 8'h01, 8'hFC);
      idle(1);
      push_seg("z_e2", 8'h01, 8'hE0);
      idle(2);
      push_seg("z_digit1", 8'h02, ZERO_DIG);
      idle(4);
      push_seg("z_digit2", 8'h04, ZERO_DIG);
      idle(4);
      push_seg("z_digit3", 8'h08, ZERO_DIG);
      idle(4);
      push_seg("z_digit0", 8'h01, 8'hE0);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge ledclk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
